// File: rtl/frame_streamer_pkg.sv
// Shared types for the optical-flow pixel stream:
// pixel type, sideband flags and streamer FSM states.
package of_stream_pkg;

  localparam int PIX_W      = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int CREDITS    = 3;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_HBLANK,
    ST_DRAIN
  } stream_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } stream_flags_t;

endpackage

// File: rtl/frame_streamer_if.sv
// Valid/ready pixel stream with frame/line sideband.
// master drives pixels, slave returns ready.
interface frame_streamer_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         data_valid;
  logic                         data_ready;
  logic                         sof;
  logic                         eol;
  logic                         eof;

  modport master (
    output data_out,
    output data_valid,
    output sof,
    output eol,
    output eof,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  sof,
    input  eol,
    input  eof,
    output data_ready
  );

endinterface

// File: rtl/frame_streamer_fifo.sv
// Small synchronous FIFO of pixel + flags entries.
// Head outputs read zero while the FIFO is empty.
module stream_fifo
  import of_stream_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DW    = PIX_W,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic signed [DW-1:0] push_data,
  input  stream_flags_t        push_flags,
  input  logic                 pop,
  output logic signed [DW-1:0] head_data,
  output stream_flags_t        head_flags,
  output logic                 head_valid,
  output logic [CW-1:0]        count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] data_q [DEPTH];
  stream_flags_t flag_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  assign head_data  = head_valid ? data_q[rd_ptr] : '0;
  assign head_flags = head_valid ? flag_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        flag_q[wr_ptr] <= push_flags;
        wr_ptr         <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Raster frame RAM reader emitting a row-major pixel
// stream with sof/eol/eof and credit-limited reads.
module frame_streamer
  import of_stream_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int DATA_WIDTH = PIX_W,
  parameter int HBLANK     = 0,
  parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
  frame_streamer_if.master             strm
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  stream_state_e           state;
  logic [XW-1:0]           col;
  logic [YW-1:0]           row;
  logic [7:0]              hb_cnt;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic                    ret_valid;
  stream_flags_t           ret_flags;
  stream_flags_t           iss_flags;
  stream_flags_t           head_flags;
  logic signed [DATA_WIDTH-1:0] head_data;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           occ;
  logic                    head_valid;
  logic                    pop;
  logic                    last_col;
  logic                    last_row;
  logic                    eof_hs;

  assign last_col = (col == XW'(WIDTH - 1));
  assign last_row = (row == YW'(HEIGHT - 1));

  // credit counts FIFO entries plus the read whose data is returning
  assign occ       = fifo_count + CW'(ret_valid);
  assign mem_rd_en = (state == ST_READ) && (occ < CW'(CREDITS));
  assign mem_addr  = mem_rd_en ? nxt_addr : last_addr;

  assign iss_flags.sof = (col == '0) && (row == '0);
  assign iss_flags.eol = last_col;
  assign iss_flags.eof = last_col && last_row;

  assign pop    = head_valid & strm.data_ready;
  assign eof_hs = pop & head_flags.eof;

  assign strm.data_valid = head_valid;
  assign strm.data_out   = head_data;
  assign strm.sof        = head_flags.sof;
  assign strm.eol        = head_flags.eol;
  assign strm.eof        = head_flags.eof;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ret_valid),
    .push_data  (mem_rd_data),
    .push_flags (ret_flags),
    .pop        (pop),
    .head_data  (head_data),
    .head_flags (head_flags),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      col       <= '0;
      row       <= '0;
      hb_cnt    <= '0;
      nxt_addr  <= '0;
      last_addr <= '0;
      ret_valid <= 1'b0;
      ret_flags <= '0;
    end else begin
      done      <= 1'b0;
      ret_valid <= mem_rd_en;
      if (mem_rd_en) begin
        ret_flags <= iss_flags;
        last_addr <= nxt_addr;
        nxt_addr  <= nxt_addr + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_READ;
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            nxt_addr <= '0;
          end
        end
        ST_READ: begin
          if (mem_rd_en) begin
            if (!last_col) begin
              col <= col + 1'b1;
            end else begin
              col <= '0;
              if (last_row) begin
                state <= ST_DRAIN;
              end else begin
                row <= row + 1'b1;
                if (HBLANK > 0) begin
                  state  <= ST_HBLANK;
                  hb_cnt <= '0;
                end
              end
            end
          end
        end
        ST_HBLANK: begin
          if (hb_cnt == 8'(HBLANK - 1)) state <= ST_READ;
          else hb_cnt <= hb_cnt + 1'b1;
        end
        ST_DRAIN: begin
          if (eof_hs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed scoreboard bench for frame_streamer:
// 4x3 frames with and without horizontal blanking.
module tb_frame_streamer;
  import of_stream_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy0, done0, rd_en0;
  logic busy1, done1, rd_en1;
  logic [AW-1:0] addr0, addr1;
  pixel_t rd0 = '0;
  pixel_t rd1 = '0;
  pixel_t ram [16];

  frame_streamer_if #(.DATA_WIDTH(PIX_W)) s0 ();
  frame_streamer_if #(.DATA_WIDTH(PIX_W)) s1 ();

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en0) rd0 <= ram[addr0];
    if (rd_en1) rd1 <= ram[addr1];
  end

  frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(PIX_W), .HBLANK(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .busy(busy0), .done(done0),
    .mem_rd_en(rd_en0), .mem_addr(addr0),
    .mem_rd_data(rd0), .strm(s0)
  );

  frame_streamer #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(PIX_W), .HBLANK(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_addr(addr1),
    .mem_rd_data(rd1), .strm(s1)
  );

  int compared = 0;
  int mismatched = 0;
  logic [14:0] q0 [$];
  logic [14:0] q1 [$];
  int issued0 = 0;
  int accepted0 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int gap1 = 0;
  int gap_seen1 = 0;
  bit stall0 = 0;
  bit eof_hs0 = 0;
  bit eof_hs1 = 0;
  bit gap_on1 = 0;
  logic [15:0] snap0 = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] e);
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, e);
    end
  endtask

  function automatic logic [14:0] exp_pix(int i, bit neg);
    pixel_t d;
    d = neg ? pixel_t'(-i - 1) : pixel_t'(i);
    return {d, i == 0, (i % W) == W - 1, i == N - 1};
  endfunction

  task automatic push_frame(bit neg, bit both);
    for (int i = 0; i < N; i++) begin
      q0.push_back(exp_pix(i, neg));
      if (both) q1.push_back(exp_pix(i, neg));
    end
  endtask

  task automatic mon0();
    logic hs;
    logic [14:0] e;
    hs = s0.data_valid && s0.data_ready;
    if (rd_en0) begin
      chk("credit_lt3", 32'(issued0 - accepted0 < 3), 1);
      issued0++;
    end
    if (stall0)
      chk("stall_hold", {s0.data_valid, s0.data_out,
          s0.sof, s0.eol, s0.eof}, snap0);
    if (done0 || eof_hs0) chk("done0_timing", done0, eof_hs0);
    if (done0) done_cnt0++;
    eof_hs0 = hs && s0.eof;
    if (hs) begin
      chk("sb0_avail", q0.size() != 0, 1);
      e = 'x;
      if (q0.size() != 0) e = q0.pop_front();
      chk("pix0", {s0.data_out, s0.sof, s0.eol, s0.eof}, e);
      accepted0++;
    end
    stall0 = s0.data_valid && !s0.data_ready;
    snap0 = {s0.data_valid, s0.data_out,
             s0.sof, s0.eol, s0.eof};
  endtask

  task automatic mon1();
    logic hs;
    logic [14:0] e;
    hs = s1.data_valid && s1.data_ready;
    if (done1 || eof_hs1) chk("done1_timing", done1, eof_hs1);
    if (done1) done_cnt1++;
    eof_hs1 = hs && s1.eof;
    if (hs) begin
      if (gap_on1) begin
        chk("hblank_gap", gap1, 2);
        gap_seen1++;
      end
      gap_on1 = s1.eol && !s1.eof;
      gap1 = 0;
      chk("sb1_avail", q1.size() != 0, 1);
      e = 'x;
      if (q1.size() != 0) e = q1.pop_front();
      chk("pix1", {s1.data_out, s1.sof, s1.eol, s1.eof}, e);
    end else if (gap_on1 && !s1.data_valid) begin
      gap1++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon0();
    mon1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic run_to_done0(input int max);
    int cyc;
    cyc = 0;
    while (!done0 && cyc < max) begin
      tick();
      cyc++;
    end
    chk("done0_reached", done0, 1);
    tick();
  endtask

  initial begin
    int lat;
    int cyc;
    int stall_left;
    bit stalled;
    bit pulsed;

    for (int i = 0; i < 16; i++) ram[i] = pixel_t'(i);
    s0.data_ready = 1'b1;
    s1.data_ready = 1'b1;

    // reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out0", {busy0, done0, rd_en0, addr0,
        s0.data_valid, s0.data_out, s0.sof, s0.eol,
        s0.eof}, 0);
    chk("rst_out1", {busy1, done1, rd_en1, addr1,
        s1.data_valid, s1.data_out, s1.sof, s1.eol,
        s1.eof}, 0);
    rst_n = 1'b1;
    tick();

    // A: ramp frame, ready high, both blanking variants
    push_frame(0, 1);
    start0 = 1'b1;
    start1 = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        chk("first_read", {busy0, rd_en0, addr0},
            {2'b11, AW'(0)});
        start0 = 1'b0;
        start1 = 1'b0;
      end
    end while (!s0.data_valid && lat < 20);
    chk("first_valid_lat", lat, 3);
    chk("first_sof", s0.sof, 1);
    while (!done0 && lat < 100) begin
      tick();
      lat++;
    end
    chk("frame_cycles", lat, N + 3);
    repeat (10) tick();
    chk("A_sb0_empty", q0.size(), 0);
    chk("A_sb1_empty", q1.size(), 0);
    chk("A_done0_cnt", done_cnt0, 1);
    chk("A_done1_cnt", done_cnt1, 1);
    chk("A_gap_count", gap_seen1, 2);

    // B: random backpressure, 10-cycle stall on pixel 5
    push_frame(0, 0);
    pulse_start0();
    cyc = 0;
    stalled = 0;
    stall_left = 0;
    while (!done0 && cyc < 400) begin
      if (stall_left > 0) begin
        s0.data_ready = 1'b0;
        stall_left--;
      end else if (!stalled && s0.data_valid &&
                   s0.data_out == 5) begin
        stalled = 1;
        stall_left = 9;
        s0.data_ready = 1'b0;
      end else begin
        s0.data_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    s0.data_ready = 1'b1;
    chk("B_done0_reached", done0, 1);
    tick();
    chk("B_stall_hit", stalled, 1);
    chk("B_sb0_empty", q0.size(), 0);
    chk("B_done0_cnt", done_cnt0, 2);

    // C: negative pixel values
    for (int i = 0; i < N; i++) ram[i] = pixel_t'(-i - 1);
    push_frame(1, 0);
    pulse_start0();
    run_to_done0(100);
    chk("C_sb0_empty", q0.size(), 0);
    chk("C_done0_cnt", done_cnt0, 3);

    // D: start re-pulsed mid-frame
    for (int i = 0; i < N; i++) ram[i] = pixel_t'(i);
    push_frame(0, 0);
    pulse_start0();
    pulsed = 0;
    cyc = 0;
    while (!done0 && cyc < 100) begin
      start0 = 1'b0;
      if (!pulsed && s0.data_valid && s0.data_out == 4) begin
        start0 = 1'b1;
        pulsed = 1;
      end
      tick();
      cyc++;
    end
    start0 = 1'b0;
    chk("D_done0_reached", done0, 1);
    repeat (20) tick();
    chk("D_pulsed", pulsed, 1);
    chk("D_done0_cnt", done_cnt0, 4);
    chk("D_idle", {busy0, s0.data_valid}, 0);
    chk("D_sb0_empty", q0.size(), 0);

    // E: reset mid-frame then a clean restart
    push_frame(0, 0);
    pulse_start0();
    cyc = 0;
    while (!(s0.data_valid && s0.data_out == 6) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("E_at_pix6", s0.data_out, 6);
    rst_n = 1'b0;
    tick();
    chk("E_rst_out0", {busy0, done0, rd_en0, addr0,
        s0.data_valid, s0.data_out, s0.sof, s0.eol,
        s0.eof}, 0);
    q0.delete();
    issued0 = 0;
    accepted0 = 0;
    stall0 = 0;
    eof_hs0 = 0;
    rst_n = 1'b1;
    tick();
    push_frame(0, 0);
    pulse_start0();
    run_to_done0(100);
    chk("E_sb0_empty", q0.size(), 0);
    chk("E_done0_cnt", done_cnt0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
